// File: rtl/clks_alot_p.sv
// Shared types for the clks_alot event path: rate counter width, half-rate
// configuration and generator state encoding.
package clks_alot_p;

    localparam int unsigned RATE_COUNTER_WIDTH = 8;

    typedef logic [RATE_COUNTER_WIDTH-1:0] rate_count_t;

    typedef struct packed {
        rate_count_t active_half_minus_one;
        rate_count_t idle_half_minus_one;
    } half_rate_config_s;

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_ACTIVE,
        GEN_IDLE_PHASE
    } gen_state_e;

endpackage

// File: rtl/clock_event_generator_slot.sv
// Single-entry valid/ready holding register for half-rate configs. An accepted
// config waits here until the owner applies it, or passes straight through when bypass is allowed.
module half_rate_config_slot
    import clks_alot_p::*;
(
    input  logic              sys_clk,
    input  logic              sync_rst,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  half_rate_config_s cfg_i,
    input  logic              bypass_i,
    input  logic              apply_i,
    output logic              avail_o,
    output half_rate_config_s head_o
);

    half_rate_config_s pending_q;
    logic              pending_valid_q;
    logic              accept;

    assign cfg_ready_o = ~pending_valid_q;
    assign accept      = cfg_valid_i & cfg_ready_o;
    assign avail_o     = pending_valid_q | (bypass_i & accept);
    assign head_o      = pending_valid_q ? pending_q : cfg_i;

    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
        end else if (apply_i) begin
            // Apply either drains the stored entry or consumes a bypassed accept.
            pending_valid_q <= 1'b0;
        end else if (accept) begin
            pending_q       <= cfg_i;
            pending_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/clock_event_generator.sv
// Clock-like waveform generator with programmable half-periods; emits edge
// events and a live phase counter in the encoding the recovery side consumes.
module clock_event_generator
    import clks_alot_p::*;
#(
    parameter logic IDLE_LEVEL = 1'b0,
    parameter logic AUTO_START = 1'b0
) (
    input  logic                          sys_clk,
    input  logic                          sync_rst,
    input  logic                          enable_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  half_rate_config_s             cfg_i,
    output logic                          gen_clk_o,
    output logic                          event_o,
    output logic                          rising_o,
    output logic                          falling_o,
    output logic [RATE_COUNTER_WIDTH-1:0] current_rate_counter_o,
    output logic                          running_o,
    output logic                          cfg_applied_o
);

    gen_state_e        state_q, state_d;
    rate_count_t       counter_q;
    half_rate_config_s active_cfg_q;
    half_rate_config_s slot_head;
    logic              config_loaded_q;
    logic              auto_armed_q;
    logic              gen_clk_q, event_q, rising_q, falling_q, applied_q;
    logic              slot_avail, apply, accept, gen_next, level_change;

    half_rate_config_slot u_slot (
        .sys_clk     (sys_clk),
        .sync_rst    (sync_rst),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_i       (cfg_i),
        .bypass_i    (state_q == GEN_IDLE),
        .apply_i     (apply),
        .avail_o     (slot_avail),
        .head_o      (slot_head)
    );

    assign accept = cfg_valid_i & cfg_ready_o;

    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        unique case (state_q)
            GEN_IDLE: begin
                apply = slot_avail;
                if ((enable_i || auto_armed_q) && config_loaded_q) begin
                    state_d = GEN_ACTIVE;
                end
            end
            GEN_ACTIVE: begin
                if (counter_q == active_cfg_q.active_half_minus_one) begin
                    state_d = GEN_IDLE_PHASE;
                end
            end
            GEN_IDLE_PHASE: begin
                // Period boundary: the only place a running generator may adopt a new config.
                if (counter_q == active_cfg_q.idle_half_minus_one) begin
                    if (enable_i) begin
                        state_d = GEN_ACTIVE;
                        apply   = slot_avail;
                    end else begin
                        state_d = GEN_IDLE;
                    end
                end
            end
            default: state_d = GEN_IDLE;
        endcase
    end

    assign gen_next     = (state_d == GEN_ACTIVE) ? ~IDLE_LEVEL : IDLE_LEVEL;
    assign level_change = gen_next != gen_clk_q;

    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            state_q         <= GEN_IDLE;
            counter_q       <= '0;
            active_cfg_q    <= '0;
            config_loaded_q <= 1'b0;
            auto_armed_q    <= 1'b0;
            gen_clk_q       <= IDLE_LEVEL;
            event_q         <= 1'b0;
            rising_q        <= 1'b0;
            falling_q       <= 1'b0;
            applied_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= (state_d != state_q || state_d == GEN_IDLE) ? '0
                                                                      : counter_q + rate_count_t'(1);
            gen_clk_q <= gen_next;
            event_q   <= level_change;
            rising_q  <= level_change & gen_next;
            falling_q <= level_change & ~gen_next;
            applied_q <= apply;
            if (apply) begin
                active_cfg_q    <= slot_head;
                config_loaded_q <= 1'b1;
            end
            // Auto start fires once, for the very first config only.
            if (state_q == GEN_IDLE && state_d == GEN_ACTIVE) begin
                auto_armed_q <= 1'b0;
            end else if (AUTO_START && accept && !config_loaded_q) begin
                auto_armed_q <= 1'b1;
            end
        end
    end

    assign gen_clk_o              = gen_clk_q;
    assign event_o                = event_q;
    assign rising_o               = rising_q;
    assign falling_o              = falling_q;
    assign current_rate_counter_o = counter_q;
    assign running_o              = state_q != GEN_IDLE;
    assign cfg_applied_o          = applied_q;

endmodule
